// File: rtl/otp_ram_arbiter_pkg.sv
// Shared types and helpers for the OTP RAM arbiter.
// FSM state encoding, default widths and the byte-mask helper.
package otp_ram_arbiter_pkg;

  localparam int WORD_AW_DEF = 13;
  localparam int DATA_W_DEF  = 32;
  localparam int STRB_W_DEF  = DATA_W_DEF / 8;
  localparam int MAX_DW      = 128;
  localparam int MAX_SW      = MAX_DW / 8;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_BCAP,
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RSP
  } otp_state_e;

  function automatic logic [MAX_DW-1:0] bytemask(
    input logic [MAX_SW-1:0] strb
  );
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_SW; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/otp_ram_arbiter_if.sv
// Request/response bundle between bus masters and the arbiter.
// master modport faces the requesters, slave modport faces the arbiter.
interface otp_ram_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int BUS_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32
);

  localparam int SW = DATA_WIDTH / 8;

  logic [NUM_MASTERS-1:0]            m_req_valid;
  logic [NUM_MASTERS-1:0]            m_req_ready;
  logic [NUM_MASTERS-1:0]            m_req_we;
  logic [NUM_MASTERS*BUS_WIDTH-1:0]  m_req_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_req_wdata;
  logic [NUM_MASTERS*SW-1:0]         m_req_wstrb;
  logic [NUM_MASTERS-1:0]            m_rsp_valid;
  logic [DATA_WIDTH-1:0]             m_rsp_rdata;
  logic                              m_rsp_err;

  modport master (
    output m_req_valid,
    output m_req_we,
    output m_req_addr,
    output m_req_wdata,
    output m_req_wstrb,
    input  m_req_ready,
    input  m_rsp_valid,
    input  m_rsp_rdata,
    input  m_rsp_err
  );

  modport slave (
    input  m_req_valid,
    input  m_req_we,
    input  m_req_addr,
    input  m_req_wdata,
    input  m_req_wstrb,
    output m_req_ready,
    output m_rsp_valid,
    output m_rsp_rdata,
    output m_rsp_err
  );

endinterface

// File: rtl/otp_ram_arbiter_rr.sv
// N-way round-robin grant with a rotating priority pointer.
// Search starts at the pointer; pointer moves past the winner.
module otp_rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] win,
  output logic          any
);

  logic [PW-1:0] ptr_q;
  int            idx;

  // first requester at or above the pointer, wrapping at N-1
  always_comb begin
    grant = '0;
    win   = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (en && !any && req[idx]) begin
        any        = 1'b1;
        win        = PW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // pointer advances to winner+1 only when a grant is issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (any) begin
      ptr_q <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/otp_ram_arbiter.sv
// N-master OTP-emulating SRAM front end: boot fuse scan, reads, 0->1 programs.
// Optional macro OTP_WRITE_LOCK_EN refuses programs at or above LOCK_BASE.
module otp_ram_arbiter
  import otp_ram_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int BUS_WIDTH   = 32,
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int WORD_AW     = WORD_AW_DEF,
  parameter logic [WORD_AW-1:0] DBG_WORD  = '0,
  parameter int DBG_BIT     = 0,
  parameter logic [WORD_AW-1:0] LOCK_BASE = 13'h1000
) (
  input  logic                    clk,
  input  logic                    reset,
  otp_ram_arbiter_if.slave        bus,
  output logic [BUS_WIDTH-1:0]    s_ram_raddr,
  output logic [BUS_WIDTH-1:0]    s_ram_waddr,
  output logic                    s_ram_ren,
  input  logic [DATA_WIDTH-1:0]   s_ram_rdata,
  output logic [DATA_WIDTH-1:0]   s_ram_wdata,
  output logic [DATA_WIDTH/8-1:0] s_ram_wen,
  output logic                    secure_debug_enable
);

  localparam int N  = NUM_MASTERS;
  localparam int SW = DATA_WIDTH / 8;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  otp_state_e state_q, state_d;

  logic [N-1:0]          grant;
  logic [PW-1:0]         win;
  logic                  any;
  int                    win_i;

  logic                  we_q;
  logic [WORD_AW-1:0]    idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic [N-1:0]          owner_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] merged;
  logic                  lock_hit;
  logic                  fuse_hit;
  logic                  sde_q;

  function automatic logic [BUS_WIDTH-1:0] word_addr(
    input logic [WORD_AW-1:0] w
  );
    return BUS_WIDTH'({w, 2'b00});
  endfunction

  otp_rr_arbiter #(.N(N)) u_rr (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_IDLE),
    .req   (bus.m_req_valid),
    .grant (grant),
    .win   (win),
    .any   (any)
  );

  assign win_i  = int'(win);
  assign merged = data_q
                | (wdata_q & DATA_WIDTH'(bytemask(MAX_SW'(wstrb_q))));

`ifdef OTP_WRITE_LOCK_EN
  logic err_q;
  assign lock_hit = we_q && (idx_q >= LOCK_BASE);
`else
  assign lock_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and all bus/RAM outputs; everything low while in reset
  always_comb begin
    state_d         = state_q;
    s_ram_ren       = 1'b0;
    s_ram_raddr     = '0;
    s_ram_waddr     = '0;
    s_ram_wdata     = '0;
    s_ram_wen       = '0;
    bus.m_req_ready = '0;
    bus.m_rsp_valid = '0;
    bus.m_rsp_rdata = '0;
    bus.m_rsp_err   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_BOOT: begin
          s_ram_ren   = 1'b1;
          s_ram_raddr = word_addr(DBG_WORD);
          state_d     = ST_BCAP;
        end
        ST_BCAP: state_d = ST_IDLE;
        ST_IDLE: begin
          bus.m_req_ready = grant;
          if (any) state_d = ST_RD;
        end
        ST_RD: begin
          s_ram_ren   = 1'b1;
          s_ram_raddr = word_addr(idx_q);
          state_d     = ST_CAP;
        end
        ST_CAP: state_d = (we_q && !lock_hit) ? ST_WR : ST_RSP;
        ST_WR: begin
          s_ram_waddr = word_addr(idx_q);
          s_ram_wdata = merged;
          s_ram_wen   = '1;
          state_d     = ST_RSP;
        end
        ST_RSP: begin
          bus.m_rsp_valid = owner_q;
          bus.m_rsp_rdata = data_q;
`ifdef OTP_WRITE_LOCK_EN
          bus.m_rsp_err   = err_q;
`endif
          state_d         = ST_IDLE;
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // latch the granted request, then the old word and the merged word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      owner_q <= '0;
      data_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && any) begin
        we_q    <= bus.m_req_we[win_i];
        idx_q   <= bus.m_req_addr[win_i*BUS_WIDTH+2 +: WORD_AW];
        wdata_q <= bus.m_req_wdata[win_i*DATA_WIDTH +: DATA_WIDTH];
        wstrb_q <= bus.m_req_wstrb[win_i*SW +: SW];
        owner_q <= grant;
      end
      if (state_q == ST_CAP) data_q <= s_ram_rdata;
      if (state_q == ST_WR)  data_q <= merged;
    end
  end

`ifdef OTP_WRITE_LOCK_EN
  // remember whether the captured program was refused
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == ST_CAP) begin
      err_q <= lock_hit;
    end
  end
`endif

  // debug fuse seen set in any capture or write of the fuse word
  always_comb begin
    fuse_hit = 1'b0;
    unique case (1'b1)
      (state_q == ST_BCAP): fuse_hit = s_ram_rdata[DBG_BIT];
      (state_q == ST_CAP):  fuse_hit = (idx_q == DBG_WORD)
                                     && s_ram_rdata[DBG_BIT];
      (state_q == ST_WR):   fuse_hit = (idx_q == DBG_WORD)
                                     && merged[DBG_BIT];
      default:              fuse_hit = 1'b0;
    endcase
  end

  // sticky secure-debug enable, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sde_q <= 1'b0;
    end else if (fuse_hit) begin
      sde_q <= 1'b1;
    end
  end

  assign secure_debug_enable = sde_q;

endmodule
